// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources in, stage enables/flushes and status out.
// The master drives the pipeline-side sources; the controller sits on the slave modport.
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             MemRead_EX;
  logic [4:0]       Write_Register_EX;
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             Branch_MEM;
  logic             Zero_MEM;
  logic             MemRead_MEM;
  logic             MemWrite_MEM;
  logic             Mem_Ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             EX_MEM_Write;
  logic             EX_MEM_Flush;
  logic             MEM_WB_Bubble;
  logic             PCSrc;
  logic             Mem_Error;
  logic [CNT_W-1:0] Stall_Cycles;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output MemRead_EX, Write_Register_EX, Rs_ID, Rt_ID, Branch_MEM, Zero_MEM,
           MemRead_MEM, MemWrite_MEM, Mem_Ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write,
           EX_MEM_Flush, MEM_WB_Bubble, PCSrc, Mem_Error, Stall_Cycles, Flush_Count
  );

  modport slave (
    input  MemRead_EX, Write_Register_EX, Rs_ID, Rt_ID, Branch_MEM, Zero_MEM,
           MemRead_MEM, MemWrite_MEM, Mem_Ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write,
           EX_MEM_Flush, MEM_WB_Bubble, PCSrc, Mem_Error, Stall_Cycles, Flush_Count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// MIPS32 pipeline hazard controller: load-use stalls, taken-branch flushes, and memory-wait
// freezes with a timeout watchdog, plus saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input logic                          Clk,
  input logic                          Reset,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait;
  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_req, w_mem_stall, w_taken, w_load_use;
  logic w_freeze, w_br_flush, w_lu_stall;
  logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_write, w_id_ex_flush;
  logic w_ex_mem_write, w_ex_mem_flush, w_mem_wb_bubble, w_pcsrc;

  assign w_mem_req   = bus.MemRead_MEM | bus.MemWrite_MEM;
  assign w_mem_stall = w_mem_req & ~bus.Mem_Ready;
  assign w_taken     = bus.Branch_MEM & bus.Zero_MEM;
  assign w_load_use  = bus.MemRead_EX && (bus.Write_Register_EX != 5'd0) &&
                       ((bus.Write_Register_EX == bus.Rs_ID) ||
                        (bus.Write_Register_EX == bus.Rt_ID));

  // Hazard arbitration: memory stall beats a taken branch, which beats load-use.
  always_comb begin
    w_freeze   = 1'b0;
    w_br_flush = 1'b0;
    w_lu_stall = 1'b0;
    if (!Reset) begin
      unique case (r_state)
        StRun: begin
          if (w_mem_stall)     w_freeze   = 1'b1;
          else if (w_taken)    w_br_flush = 1'b1;
          else if (w_load_use) w_lu_stall = 1'b1;
        end
        StMemWait: w_freeze = ~bus.Mem_Ready;
        StFault:   w_freeze = 1'b1;
        default:   w_freeze = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_pc_write      = ~(w_freeze | w_lu_stall);
    w_if_id_write   = ~(w_freeze | w_lu_stall);
    w_id_ex_write   = ~w_freeze;
    w_ex_mem_write  = ~w_freeze;
    w_if_id_flush   = Reset | w_br_flush;
    w_id_ex_flush   = Reset | w_br_flush | w_lu_stall;
    w_ex_mem_flush  = Reset | w_br_flush;
    w_mem_wb_bubble = Reset | w_freeze;
    w_pcsrc         = w_br_flush;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= StRun;
      r_wait      <= '0;
      r_mem_error <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_mem_stall) begin
            r_state <= StMemWait;
            r_wait  <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (bus.Mem_Ready) begin
            r_state <= StRun;
            r_wait  <= '0;
          end else if (r_wait == WaitW'(MEM_TIMEOUT)) begin
            r_state     <= StFault;
            r_mem_error <= 1'b1;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StFault: r_state <= StFault;
        default: r_state <= StFault;
      endcase
      if (!w_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_br_flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_Write      = w_pc_write;
  assign bus.IF_ID_Write   = w_if_id_write;
  assign bus.IF_ID_Flush   = w_if_id_flush;
  assign bus.ID_EX_Write   = w_id_ex_write;
  assign bus.ID_EX_Flush   = w_id_ex_flush;
  assign bus.EX_MEM_Write  = w_ex_mem_write;
  assign bus.EX_MEM_Flush  = w_ex_mem_flush;
  assign bus.MEM_WB_Bubble = w_mem_wb_bubble;
  assign bus.PCSrc         = w_pcsrc;
  assign bus.Mem_Error     = r_mem_error;
  assign bus.Stall_Cycles  = r_stall_cnt;
  assign bus.Flush_Count   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; narrow counters so saturation is reachable.
module tb_pipeline_hazard_controller;
  localparam int unsigned CntW = 4;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
  //  EX_MEM_Write, EX_MEM_Flush, MEM_WB_Bubble, PCSrc}
  localparam logic [8:0] CtrlDef    = 9'b110101000;
  localparam logic [8:0] CtrlFreeze = 9'b000000010;
  localparam logic [8:0] CtrlBranch = 9'b111111101;
  localparam logic [8:0] CtrlLdUse  = 9'b000111000;
  localparam logic [8:0] CtrlReset  = 9'b111111110;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_controller_if #(.CNT_W(CntW)) bus ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(15), .CNT_W(CntW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [8:0] ctrl;
  assign ctrl = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
                 bus.ID_EX_Flush, bus.EX_MEM_Write, bus.EX_MEM_Flush, bus.MEM_WB_Bubble,
                 bus.PCSrc};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.MemRead_EX = 1'b0; bus.Write_Register_EX = 5'd0; bus.Rs_ID = 5'd0; bus.Rt_ID = 5'd0;
    bus.Branch_MEM = 1'b0; bus.Zero_MEM = 1'b0; bus.MemRead_MEM = 1'b0;
    bus.MemWrite_MEM = 1'b0; bus.Mem_Ready = 1'b0;
  endtask

  // Inputs settle 1 ns after the edge, comb outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    tick();
    settle();
    check_val("reset_ctrl", 32'(ctrl), 32'(CtrlReset));
    tick();
    Reset = 1'b0;
    settle();
    check_val("post_reset_ctrl", 32'(ctrl), 32'(CtrlDef));
    check_val("post_reset_stall", 32'(bus.Stall_Cycles), 0);
    check_val("post_reset_flush", 32'(bus.Flush_Count), 0);
    check_val("post_reset_err", 32'(bus.Mem_Error), 0);

    // lw $2 in EX, consumer of $2 (rs) in ID
    bus.MemRead_EX = 1'b1; bus.Write_Register_EX = 5'd2; bus.Rs_ID = 5'd2; bus.Rt_ID = 5'd7;
    settle();
    check_val("ldu_rs_ctrl", 32'(ctrl), 32'(CtrlLdUse));
    tick();
    idle();
    settle();
    check_val("ldu_rs_stall", 32'(bus.Stall_Cycles), 1);
    check_val("ldu_after_ctrl", 32'(ctrl), 32'(CtrlDef));

    // lw $0 never hazards
    bus.MemRead_EX = 1'b1; bus.Write_Register_EX = 5'd0; bus.Rs_ID = 5'd0; bus.Rt_ID = 5'd0;
    settle();
    check_val("ldu_r0_ctrl", 32'(ctrl), 32'(CtrlDef));
    tick();
    // rt match
    bus.Write_Register_EX = 5'd5; bus.Rs_ID = 5'd3; bus.Rt_ID = 5'd5;
    settle();
    check_val("ldu_rt_ctrl", 32'(ctrl), 32'(CtrlLdUse));
    tick();
    // same regs, but EX holds a non-load
    bus.MemRead_EX = 1'b0;
    settle();
    check_val("no_load_ctrl", 32'(ctrl), 32'(CtrlDef));
    check_val("ldu_rt_stall", 32'(bus.Stall_Cycles), 2);
    tick();
    idle();

    // Taken and not-taken branches
    bus.Branch_MEM = 1'b1; bus.Zero_MEM = 1'b1;
    settle();
    check_val("br_taken_ctrl", 32'(ctrl), 32'(CtrlBranch));
    tick();
    bus.Zero_MEM = 1'b0;
    settle();
    check_val("br_taken_cnt", 32'(bus.Flush_Count), 1);
    check_val("br_nt_ctrl", 32'(ctrl), 32'(CtrlDef));
    tick();
    check_val("br_nt_cnt", 32'(bus.Flush_Count), 1);

    // Load-use and taken branch together: branch wins
    bus.Zero_MEM = 1'b1;
    bus.MemRead_EX = 1'b1; bus.Write_Register_EX = 5'd9; bus.Rs_ID = 5'd9;
    settle();
    check_val("br_ldu_ctrl", 32'(ctrl), 32'(CtrlBranch));
    tick();
    idle();
    check_val("br_ldu_stall", 32'(bus.Stall_Cycles), 2);
    check_val("br_ldu_flush", 32'(bus.Flush_Count), 2);

    // Zero-wait load
    bus.MemRead_MEM = 1'b1; bus.Mem_Ready = 1'b1;
    settle();
    check_val("zero_wait_ctrl", 32'(ctrl), 32'(CtrlDef));
    tick();
    idle();

    // Store waits 3 cycles; a taken branch in MEM is held off by the freeze
    bus.MemWrite_MEM = 1'b1; bus.Branch_MEM = 1'b1; bus.Zero_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val($sformatf("store_wait%0d", i), 32'(ctrl), 32'(CtrlFreeze));
      tick();
    end
    bus.Mem_Ready = 1'b1; bus.Branch_MEM = 1'b0; bus.Zero_MEM = 1'b0;
    settle();
    check_val("store_release", 32'(ctrl), 32'(CtrlDef));
    tick();
    idle();
    check_val("store_stall", 32'(bus.Stall_Cycles), 5);
    check_val("store_flush", 32'(bus.Flush_Count), 2);

    // Watchdog: Mem_Ready never arrives
    bus.MemRead_MEM = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      settle();
      check_val($sformatf("to_freeze%0d", i), 32'(ctrl), 32'(CtrlFreeze));
      tick();
      if (i == 10) check_val("stall_sat_edge", 32'(bus.Stall_Cycles), 15);
      if (i == 15) check_val("to_err_early", 32'(bus.Mem_Error), 0);
    end
    check_val("to_err_set", 32'(bus.Mem_Error), 1);
    bus.Mem_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val($sformatf("fault_hold%0d", i), 32'(ctrl), 32'(CtrlFreeze));
      tick();
    end
    check_val("fault_err_sticky", 32'(bus.Mem_Error), 1);
    check_val("stall_sat", 32'(bus.Stall_Cycles), 15);

    // Reset out of FAULT
    idle();
    Reset = 1'b1;
    settle();
    check_val("rst_fault_ctrl", 32'(ctrl), 32'(CtrlReset));
    tick();
    Reset = 1'b0;
    settle();
    check_val("rst_fault_err", 32'(bus.Mem_Error), 0);
    check_val("rst_fault_stall", 32'(bus.Stall_Cycles), 0);
    check_val("rst_fault_flush", 32'(bus.Flush_Count), 0);
    check_val("rst_fault_run", 32'(ctrl), 32'(CtrlDef));

    // Flush counter saturation
    bus.Branch_MEM = 1'b1; bus.Zero_MEM = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    idle();
    check_val("flush_sat", 32'(bus.Flush_Count), 15);
    check_val("flush_sat_stall", 32'(bus.Stall_Cycles), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end
endmodule
